// File: rtl/vid_pkg.sv
// vid_pkg: types and constants shared by the video write packer and its FIFO.
package vid_pkg;
    localparam int PIX_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;
    typedef struct packed {
        logic sof;
        logic eol;
    } tag_t;
    localparam int TAG_W = $bits(tag_t);
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO that drops a write when full and not popping.
// Ports: clk/rst (sync, active-high); i_wr_en/i_wr_data push; i_rd_en pop;
//        o_rd_data head word; o_full/o_empty status; o_drop pulses on a lost write.
module sync_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic             w_wr, w_rd;
    assign o_empty   = r_wr_ptr == r_rd_ptr;
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd      = i_rd_en & ~o_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr      = i_wr_en & (~o_full | w_rd);
    assign o_drop    = i_wr_en & o_full & ~w_rd;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/vid_wr_packer.sv
// vid_wr_packer: packs RGB565 pixels of a frame into wide words with sof/eol tags and queues them.
// Ports: clk/rst (sync, active-high); img_vs/img_de/img_data_en/img_data pixel input;
//        wr_data/wr_valid/wr_ready/wr_sof/wr_eol word output; frame_done pulse;
//        ovf_err/frame_err sticky error flags.
module vid_wr_packer
    import vid_pkg::*;
#(
    parameter int IMG_W      = 1024,
    parameter int IMG_H      = 768,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  img_vs,
    input  logic                  img_de,
    input  logic                  img_data_en,
    input  logic [PIX_W-1:0]      img_data,
    output logic [PIX_W*PACK-1:0] wr_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  wr_sof,
    output logic                  wr_eol,
    output logic                  frame_done,
    output logic                  ovf_err,
    output logic                  frame_err
);
    localparam int WW = PIX_W * PACK;
    localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int LW = IMG_H > 1 ? $clog2(IMG_H) : 1;
    localparam int SW = PACK > 1 ? $clog2(PACK) : 1;
    state_t          r_state;
    logic            r_vs_d, r_push, r_frame_done, r_ovf_err, r_frame_err;
    logic [CW-1:0]   r_col;
    logic [LW-1:0]   r_line;
    logic [SW-1:0]   r_slot;
    logic [WW-1:0]   r_pack, r_push_data, w_word;
    tag_t            r_push_tag;
    logic            w_fs, w_strobe, w_col_last, w_line_last, w_slot_last;
    logic            w_full, w_empty, w_drop;
    logic [WW+TAG_W-1:0] w_rd_data;
    assign w_fs        = img_vs & ~r_vs_d;
    assign w_strobe    = img_de & img_data_en;
    assign w_col_last  = r_col == CW'(IMG_W - 1);
    assign w_line_last = r_line == LW'(IMG_H - 1);
    assign w_slot_last = r_slot == SW'(PACK - 1);
    // completed word: earlier slots from the pack register, top slot straight from the input
    always_comb begin
        w_word = r_pack;
        w_word[PIX_W*(PACK-1) +: PIX_W] = img_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vs_d       <= 1'b0;
            r_col        <= '0;
            r_line       <= '0;
            r_slot       <= '0;
            r_pack       <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_push_tag   <= '0;
            r_frame_done <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_vs_d       <= img_vs;
            r_push       <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_fs) begin
                // ACTIVE never holds a complete frame, so a restart here is always short
                if (r_state == ST_ACTIVE) r_frame_err <= 1'b1;
                r_state <= ST_ACTIVE;
                r_col   <= '0;
                r_line  <= '0;
                r_slot  <= '0;
            end else if (w_strobe) begin
                if (r_state == ST_DONE) r_frame_err <= 1'b1;
                if (r_state == ST_ACTIVE) begin
                    r_pack[int'(r_slot)*PIX_W +: PIX_W] <= img_data;
                    r_slot <= w_slot_last ? '0 : r_slot + 1'b1;
                    r_col  <= w_col_last ? '0 : r_col + 1'b1;
                    if (w_col_last) r_line <= r_line + 1'b1;
                    if (w_slot_last) begin
                        r_push         <= 1'b1;
                        r_push_data    <= w_word;
                        r_push_tag.sof <= (r_line == '0) && (r_col == CW'(PACK - 1));
                        r_push_tag.eol <= w_col_last;
                    end
                    if (w_col_last && w_line_last) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
            end
            if (w_drop) r_ovf_err <= 1'b1;
        end
    end
    sync_fifo #(
        .WIDTH (WW + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_push),
        .i_wr_data ({r_push_tag, r_push_data}),
        .i_rd_en   (wr_ready & wr_valid),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_drop    (w_drop)
    );
    // outputs forced low during reset, before the registers have been cleared
    assign wr_valid                  = ~w_empty & ~rst;
    assign {wr_sof, wr_eol, wr_data} = wr_valid ? w_rd_data : '0;
    assign frame_done                = r_frame_done & ~rst;
    assign ovf_err                   = r_ovf_err & ~rst;
    assign frame_err                 = r_frame_err & ~rst;
endmodule
